// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: add/sub/logic finish in one cycle, mul (shift-add) and
// div (restoring) iterate once per bit. A start pulse launches an op and a
// one-cycle done pulse marks when the outputs are valid.
// Optional feature macro: ULA_FLAGS_EN enables the {N,Z,C,V} flag register;
// without it, flags is tied to zero.
module ula_multiciclo #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLOCK_27,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div0,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             div0_q, div0_d;
    logic             wr_out;

    // hi_q/lo_q are shared: accumulator/multiplier for mul, remainder/quotient for div
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   rem_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo;

    assign mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_ge   = (rem_sh >= {1'b0, b_q});
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_quo  = {lo_q[WIDTH-2:0], div_ge};

    // Next-state, iteration step and output-load decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        div0_d      = div0_q;
        wr_out      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    b_d   = op_b;
                    cnt_d = '0;
                    if (op == OP_MUL || (op == OP_DIV && op_b != '0)) begin
                        hi_d    = '0;
                        lo_d    = op_a;
                        state_d = CALC;
                    end else begin
                        state_d     = DONE;
                        wr_out      = 1'b1;
                        div0_d      = 1'b0;
                        result_hi_d = '0;
                        case (op)
                            OP_ADD:  result_d = op_a + op_b;
                            OP_SUB:  result_d = op_a - op_b;
                            OP_DIV: begin
                                // divide by zero short-circuits the iterative path
                                result_d    = '1;
                                result_hi_d = op_a;
                                div0_d      = 1'b1;
                            end
                            OP_AND:  result_d = op_a & op_b;
                            OP_OR:   result_d = op_a | op_b;
                            OP_XOR:  result_d = op_a ^ op_b;
                            default: result_d = ~(op_a | op_b);
                        endcase
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end else begin
                    hi_d = div_rem;
                    lo_d = div_quo;
                end
                if (cnt_q == LAST_IT) begin
                    state_d     = DONE;
                    wr_out      = 1'b1;
                    result_d    = lo_d;
                    result_hi_d = hi_d;
                    div0_d      = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible outputs; reset aborts any op in flight
    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            div0_q      <= div0_d;
        end
    end

    // Captured operands and iteration working registers (no reset needed)
    always_ff @(posedge CLOCK_27) begin
        op_q <= op_d;
        b_q  <= b_d;
        hi_q <= hi_d;
        lo_q <= lo_d;
    end

`ifdef ULA_FLAGS_EN
    logic [3:0]     flags_q;
    logic [WIDTH:0] add_c, sub_c;
    logic           c_d, v_d;

    assign add_c = {1'b0, op_a} + {1'b0, op_b};
    assign sub_c = {1'b0, op_a} - {1'b0, op_b};

    // Carry/overflow only arise from add/sub, which launch from IDLE with live operands
    always_comb begin
        c_d = 1'b0;
        v_d = 1'b0;
        if (state_q == IDLE) begin
            if (op == OP_ADD) begin
                c_d = add_c[WIDTH];
                v_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_c[WIDTH-1] != op_a[WIDTH-1]);
            end else if (op == OP_SUB) begin
                c_d = sub_c[WIDTH];
                v_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_c[WIDTH-1] != op_a[WIDTH-1]);
            end
        end
    end

    // Flag register, refreshed together with the result
    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            flags_q <= '0;
        end else if (wr_out) begin
            flags_q <= {result_d[WIDTH-1], (result_d == '0), c_d, v_d};
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0;
`endif

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign div0      = div0_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo (WIDTH=8): spec-level model with per-cycle compare,
// plus directed ops with hand-computed expectations.
`timescale 1ns/1ps
module tb_ula_multiciclo;
    localparam int W = 8;
`ifdef ULA_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic [W-1:0] result, result_hi;
    logic [3:0]   flags;
    logic         div0, busy, done;

    int checks = 0;
    int failures = 0;
    bit tb_done = 1'b0;

    ula_multiciclo #(.WIDTH(W)) dut (
        .CLOCK_27 (clk),
        .RESET    (rst),
        .start    (start),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .result_hi(result_hi),
        .flags    (flags),
        .div0     (div0),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic [3:0]   f;
        logic         d0;
    } res_t;

    function automatic res_t model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t x;
        int ua, ub, sa, sb, t, s;
        logic c, v;
        logic [2*W-1:0] p;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        x.r = '0; x.rh = '0; x.d0 = 1'b0; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin t = ua + ub; x.r = t[W-1:0]; c = (t > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            3'd1: begin t = ua - ub; x.r = t[W-1:0]; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
            3'd2: begin p = 16'(ua * ub); x.r = p[W-1:0]; x.rh = p[2*W-1:W]; end
            3'd3: begin
                if (ub == 0) begin x.r = 8'hFF; x.rh = a; x.d0 = 1'b1; end
                else begin x.r = 8'(ua / ub); x.rh = 8'(ua % ub); end
            end
            3'd4: x.r = a & b;
            3'd5: x.r = a | b;
            3'd6: x.r = a ^ b;
            default: x.r = ~(a | b);
        endcase
        x.f = FLAGS_ON ? {x.r[W-1], (x.r == 8'd0), c, v} : 4'b0;
        return x;
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [W-1:0] b);
        if (o == 3'd2 || (o == 3'd3 && b != 8'd0)) return W + 1;
        return 1;
    endfunction

    res_t m_out, m_pend;
    logic m_busy, m_done;
    int   m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_out <= '0; m_pend <= '0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin m_done <= 1'b1; m_out <= m_pend; end
            m_left <= m_left - 1;
        end else if (start) begin
            m_busy <= 1'b1;
            if (lat_of(op, op_b) == 1) begin
                m_done <= 1'b1;
                m_out  <= model_op(op, op_a, op_b);
            end else begin
                m_pend <= model_op(op, op_a, op_b);
                m_left <= lat_of(op, op_b) - 1;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!tb_done) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_result", result, m_out.r);
            chk("cyc_result_hi", result_hi, m_out.rh);
            chk("cyc_flags", flags, m_out.f);
            chk("cyc_div0", div0, m_out.d0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input logic [W-1:0] er, input logic [W-1:0] erh,
                          input logic [3:0] ef, input logic ed0);
        int k;
        int busy_lo;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        k = 1; busy_lo = 0;
        while (!done && k < 30) begin
            if (!busy) busy_lo++;
            @(posedge clk); #1;
            k++;
        end
        if (!busy) busy_lo++;
        chk({nm, "_latency"}, k, lat);
        chk({nm, "_busy_gap"}, busy_lo, 0);
        chk({nm, "_result"}, result, er);
        chk({nm, "_result_hi"}, result_hi, erh);
        chk({nm, "_flags"}, flags, FLAGS_ON ? ef : 4'b0);
        chk({nm, "_div0"}, div0, ed0);
        @(posedge clk);
    endtask

    initial begin
        int ndone, kdone;
        #1 rst = 1'b1;
        #1;
        chk("rst_result", result, 0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_flags", flags, 0);
        chk("rst_div0", div0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //      name     op    a       b      lat res    hi     NZCV     d0
        run_op("add",   3'd0, 8'd200, 8'd100, 1, 8'd44,  8'd0,  4'b0010, 1'b0);
        run_op("sub1",  3'd1, 8'd5,   8'd7,   1, 8'hFE,  8'd0,  4'b1010, 1'b0);
        run_op("sub0",  3'd1, 8'd7,   8'd7,   1, 8'h00,  8'd0,  4'b0100, 1'b0);
        run_op("addv",  3'd0, 8'd100, 8'd100, 1, 8'hC8,  8'd0,  4'b1001, 1'b0);
        run_op("subv",  3'd1, 8'h80,  8'h01,  1, 8'h7F,  8'd0,  4'b0001, 1'b0);
        run_op("mul",   3'd2, 8'd200, 8'd3,   9, 8'h58,  8'h02, 4'b0000, 1'b0);
        run_op("mulmx", 3'd2, 8'hFF,  8'hFF,  9, 8'h01,  8'hFE, 4'b0000, 1'b0);
        run_op("div",   3'd3, 8'd100, 8'd7,   9, 8'd14,  8'd2,  4'b0000, 1'b0);
        run_op("divmx", 3'd3, 8'd255, 8'd16,  9, 8'd15,  8'd15, 4'b0000, 1'b0);
        run_op("divsm", 3'd3, 8'd5,   8'd9,   9, 8'd0,   8'd5,  4'b0100, 1'b0);
        run_op("and",   3'd4, 8'hF0,  8'h3C,  1, 8'h30,  8'd0,  4'b0000, 1'b0);
        run_op("or",    3'd5, 8'hF0,  8'h0F,  1, 8'hFF,  8'd0,  4'b1000, 1'b0);
        run_op("xor",   3'd6, 8'hAA,  8'hAA,  1, 8'h00,  8'd0,  4'b0100, 1'b0);
        run_op("nor",   3'd7, 8'd0,   8'd0,   1, 8'hFF,  8'd0,  4'b1000, 1'b0);
        run_op("div0",  3'd3, 8'd9,   8'd0,   1, 8'hFF,  8'd9,  4'b1000, 1'b1);
        run_op("clr0",  3'd0, 8'd1,   8'd2,   1, 8'd3,   8'd0,  4'b0000, 1'b0);
        run_op("div0b", 3'd3, 8'd9,   8'd0,   1, 8'hFF,  8'd9,  4'b1000, 1'b1);

        // mul in flight with a start+add pulse at n+3: must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd2; op_a = 8'd200; op_b = 8'd3;
        ndone = 0; kdone = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; op = 3'd0; op_a = 8'd1; op_b = 8'd1; end
            if (k == 4) start = 1'b0;
            if (done) begin ndone++; if (kdone == 0) kdone = k; end
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_done_cycle", kdone, 9);
        chk("ign_result", result, 8'h58);
        chk("ign_result_hi", result_hi, 8'h02);

        // leave div0/result set, then reset in the middle of a div
        run_op("div0c", 3'd3, 8'd9, 8'd0, 1, 8'hFF, 8'd9, 4'b1000, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 3'd3; op_a = 8'd100; op_b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_result_hi", result_hi, 0);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_div0", div0, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);

        run_op("after", 3'd0, 8'd1, 8'd1, 1, 8'd2, 8'd0, 4'b0000, 1'b0);

        tb_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
